// File: rtl/hilo_ctrl_if.sv
// HI/LO sequencer bus: EX-stage op request plus stall and HI/LO write port.
// master = pipeline side, slave = hilo_ctrl.
interface hilo_ctrl_if;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        stall;
   logic [1:0]  hilo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;

   modport master (
      output op_valid, op, src_a, src_b, flush,
      input  stall, hilo_we, hi_wdata, lo_wdata
   );

   modport slave (
      input  op_valid, op, src_a, src_b, flush,
      output stall, hilo_we, hi_wdata, lo_wdata
   );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: registered multiply, 32-step restoring divide, MTHI/MTLO.
// Optional macro HILO_DIV_EARLY_EXIT_EN: finish a divide at once when |a| < |b|.
module hilo_ctrl (
   input  logic        clk,
   input  logic        rst,
   hilo_ctrl_if.slave  bus
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t       r_state;
   state_t       w_state_nx;
   logic [4:0]   r_cnt;
   logic [31:0]  r_a;
   logic [31:0]  r_b;
   logic [31:0]  r_quo;
   logic [32:0]  r_rem;
   logic [31:0]  r_hi;
   logic [31:0]  r_lo;
   logic         r_msign;
   logic         r_neg_q;
   logic         r_neg_r;

   logic         w_acc_mul;
   logic         w_acc_div;
   logic         w_acc_dz;
   logic         w_acc_ee;
   logic         w_dsign;
   logic [31:0]  w_mag_a;
   logic [31:0]  w_mag_b;
   logic         w_early;
   logic signed [63:0] w_ma;
   logic signed [63:0] w_mb;
   logic signed [63:0] w_prod;
   logic [32:0]  w_rem_sh;
   logic         w_ge;
   logic [32:0]  w_rem_nx;
   logic [31:0]  w_quo_nx;

   function automatic logic [31:0] fix_sign(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   assign w_dsign = (bus.op == OP_DIV);
   assign w_mag_a = (w_dsign && bus.src_a[31]) ? (~bus.src_a + 32'd1) : bus.src_a;
   assign w_mag_b = (w_dsign && bus.src_b[31]) ? (~bus.src_b + 32'd1) : bus.src_b;

`ifdef HILO_DIV_EARLY_EXIT_EN
   assign w_early = (w_mag_a < w_mag_b);
`else
   assign w_early = 1'b0;
`endif

   // Multiplier operands are sign- or zero-extended so one signed multiply covers both forms
   assign w_ma   = {{32{r_msign & r_a[31]}}, r_a};
   assign w_mb   = {{32{r_msign & r_b[31]}}, r_b};
   assign w_prod = w_ma * w_mb;

   // r_quo doubles as the dividend shift register; quotient bits enter at the LSB
   assign w_rem_sh = {r_rem[31:0], r_quo[31]};
   assign w_ge     = r_rem[32] | (w_rem_sh >= {1'b0, r_b});
   assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
   assign w_quo_nx = {r_quo[30:0], w_ge};

   always_comb begin
      w_state_nx   = r_state;
      bus.stall    = 1'b0;
      bus.hilo_we  = 2'b00;
      bus.hi_wdata = r_hi;
      bus.lo_wdata = r_lo;
      w_acc_mul    = 1'b0;
      w_acc_div    = 1'b0;
      w_acc_dz     = 1'b0;
      w_acc_ee     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.op_valid) begin
               case (bus.op)
                  OP_MTHI: begin
                     bus.hilo_we  = 2'b11;
                     bus.hi_wdata = bus.src_a;
                  end
                  OP_MTLO: begin
                     bus.hilo_we  = 2'b10;
                     bus.lo_wdata = bus.src_a;
                  end
                  OP_MULT, OP_MULTU: begin
                     bus.stall  = 1'b1;
                     w_acc_mul  = 1'b1;
                     w_state_nx = S_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     bus.stall = 1'b1;
                     if (bus.src_b == 32'd0) begin
                        w_acc_dz   = 1'b1;
                        w_state_nx = S_DONE;
                     end else if (w_early) begin
                        w_acc_ee   = 1'b1;
                        w_state_nx = S_DONE;
                     end else begin
                        w_acc_div  = 1'b1;
                        w_state_nx = S_DIV;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            bus.stall  = 1'b1;
            w_state_nx = S_DONE;
         end
         S_DIV: begin
            bus.stall = 1'b1;
            if (r_cnt == 5'd31) w_state_nx = S_DONE;
         end
         S_DONE: begin
            bus.hilo_we = 2'b01;
            w_state_nx  = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase

      if (bus.flush) begin
         w_state_nx  = S_IDLE;
         bus.stall   = 1'b0;
         bus.hilo_we = 2'b00;
         w_acc_mul   = 1'b0;
         w_acc_div   = 1'b0;
         w_acc_dz    = 1'b0;
         w_acc_ee    = 1'b0;
      end

      // Outputs are held quiet for the whole reset window
      if (!rst) begin
         bus.stall    = 1'b0;
         bus.hilo_we  = 2'b00;
         bus.hi_wdata = 32'd0;
         bus.lo_wdata = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 5'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_quo   <= 32'd0;
         r_rem   <= 33'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_msign <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else begin
         r_state <= w_state_nx;

         if (w_acc_mul) begin
            r_a     <= bus.src_a;
            r_b     <= bus.src_b;
            r_msign <= (bus.op == OP_MULT);
         end

         if (w_acc_dz) begin
            r_hi <= bus.src_a;
            r_lo <= 32'hFFFF_FFFF;
         end

         if (w_acc_ee) begin
            r_hi <= bus.src_a;
            r_lo <= 32'd0;
         end

         if (w_acc_div) begin
            r_quo   <= w_mag_a;
            r_b     <= w_mag_b;
            r_rem   <= 33'd0;
            r_cnt   <= 5'd0;
            r_neg_q <= w_dsign & (bus.src_a[31] ^ bus.src_b[31]);
            r_neg_r <= w_dsign & bus.src_a[31];
         end

         if (r_state == S_MUL && !bus.flush) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
         end

         // Final iteration lands the sign-corrected results directly in HI/LO
         if (r_state == S_DIV && !bus.flush) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
               r_hi <= fix_sign(w_rem_nx[31:0], r_neg_r);
               r_lo <= fix_sign(w_quo_nx, r_neg_q);
            end
         end
      end
   end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_hilo_ctrl;

   logic clk;
   logic rst;
   hilo_ctrl_if bus();

   hilo_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [1:0]  we;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write the DUT presents must match the head of the scoreboard
   always @(negedge clk) begin
      if (bus.hilo_we !== 2'b00) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write cyc=%0d we=%b hi=%h lo=%h", cyc, bus.hilo_we, bus.hi_wdata, bus.lo_wdata);
         end else begin
            exp_t  e;
            string n;
            logic  ok;
            e  = exp_q.pop_front();
            n  = name_q.pop_front();
            ok = (bus.hilo_we === e.we) && (cyc == e.cyc);
            if (e.we == 2'b01 || e.we == 2'b11) ok = ok && (bus.hi_wdata === e.hi);
            if (e.we == 2'b01 || e.we == 2'b10) ok = ok && (bus.lo_wdata === e.lo);
            if (!ok) begin
               errors++;
               $display("FAIL %s got cyc=%0d we=%b hi=%h lo=%h expected cyc=%0d we=%b hi=%h lo=%h",
                        n, cyc, bus.hilo_we, bus.hi_wdata, bus.lo_wdata, e.cyc, e.we, e.hi, e.lo);
            end
         end
      end
   end

   task automatic chk_stall(input string n, input logic exp_s);
      checks++;
      if (bus.stall !== exp_s) begin
         errors++;
         $display("FAIL %s_stall cyc=%0d got %b expected %b", n, cyc, bus.stall, exp_s);
      end
   endtask

   task automatic chk_we0(input string n);
      checks++;
      if (bus.hilo_we !== 2'b00) begin
         errors++;
         $display("FAIL %s_we cyc=%0d got %b expected 00", n, cyc, bus.hilo_we);
      end
   endtask

   task automatic issue(input string n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int nstall, input logic [1:0] we, input logic [31:0] hi, input logic [31:0] lo);
      exp_t e;
      @(posedge clk); #1;
      bus.op_valid = 1'b1;
      bus.op       = op;
      bus.src_a    = a;
      bus.src_b    = b;
      e.cyc = cyc + nstall;
      e.we  = we;
      e.hi  = hi;
      e.lo  = lo;
      exp_q.push_back(e);
      name_q.push_back(n);
      for (int i = 0; i < nstall; i++) begin
         @(negedge clk);
         chk_stall(n, 1'b1);
      end
      @(negedge clk);
      chk_stall(n, 1'b0);
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      bus.op       = 3'b000;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b0;
      bus.op_valid = 1'b1;
      bus.op       = 3'b001;
      bus.src_a    = 32'h0000_0005;
      bus.src_b    = 32'h0000_0007;
      bus.flush    = 1'b0;

      @(negedge clk);
      chk_stall("reset_mult", 1'b0);
      chk_we0("reset_mult");
      bus.op = 3'b101;
      @(negedge clk);
      chk_stall("reset_mthi", 1'b0);
      chk_we0("reset_mthi");
      @(posedge clk); #1;
      rst          = 1'b1;
      bus.op_valid = 1'b0;
      bus.op       = 3'b000;

      issue("mult",      3'b001, 32'hFFFF_FFFD, 32'd7, 2,  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      issue("multu",     3'b010, 32'hFFFF_FFFD, 32'd7, 2,  2'b01, 32'h0000_0006, 32'hFFFF_FFEB);
      issue("div_neg",   3'b011, 32'hFFFF_FFF9, 32'd2, 33, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue("div_negb",  3'b011, 32'd7, 32'hFFFF_FFFE, 33, 2'b01, 32'h0000_0001, 32'hFFFF_FFFD);
      issue("divu",      3'b100, 32'd100, 32'd7, 33, 2'b01, 32'd2, 32'd14);
      issue("divu_zero", 3'b100, 32'd5, 32'd0, 1, 2'b01, 32'd5, 32'hFFFF_FFFF);
      issue("div_ovf",   3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 33, 2'b01, 32'd0, 32'h8000_0000);
      issue("mthi",      3'b101, 32'hDEAD_BEEF, 32'd0, 0, 2'b11, 32'hDEAD_BEEF, 32'd0);
`ifdef HILO_DIV_EARLY_EXIT_EN
      issue("divu_small", 3'b100, 32'd3, 32'd10, 1, 2'b01, 32'd3, 32'd0);
`else
      issue("divu_small", 3'b100, 32'd3, 32'd10, 33, 2'b01, 32'd3, 32'd0);
`endif

      // Invalid op codes: no write, no stall
      @(posedge clk); #1;
      bus.op_valid = 1'b1;
      bus.op       = 3'b111;
      @(negedge clk);
      chk_stall("invalid7", 1'b0);
      chk_we0("invalid7");
      @(posedge clk); #1;
      bus.op = 3'b000;
      @(negedge clk);
      chk_stall("invalid0", 1'b0);
      chk_we0("invalid0");
      @(posedge clk); #1;
      bus.op_valid = 1'b0;

      // Flush during divide iteration 10
      @(posedge clk); #1;
      bus.op_valid = 1'b1;
      bus.op       = 3'b100;
      bus.src_a    = 32'd1000;
      bus.src_b    = 32'd3;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_stall("flush_pre", 1'b1);
      end
      @(posedge clk); #1;
      bus.flush = 1'b1;
      @(negedge clk);
      chk_stall("flush", 1'b0);
      chk_we0("flush");
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.op_valid = 1'b0;
      bus.op       = 3'b000;
      @(negedge clk);
      chk_stall("flush_after", 1'b0);
      issue("mtlo_after_flush", 3'b110, 32'h0000_1234, 32'd0, 0, 2'b10, 32'd0, 32'h0000_1234);

      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_writes got %0d pending expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
